// File: rtl/boot_image_loader_pkg.sv
// Shared memory-map constants and the boot sequencer state encoding.
// The state type is also used by the debug/status readout.
package boot_image_loader_pkg;

  localparam logic [23:0] FLASH_ADDR_BIOS = 24'h10_0000;
  localparam logic [23:0] RAM_ADDR_BIOS   = 24'h70_0000;
  localparam logic [23:0] FLASH_SIZE_BIOS = 24'h02_4000;
  localparam logic [23:0] FLASH_ADDR_PAC  = 24'h1F_0000;
  localparam logic [23:0] RAM_ADDR_PAC    = 24'h77_E000;
  localparam logic [23:0] RAM_SIZE_PAC    = 24'h00_2000;

  typedef enum logic [2:0] {
    LOAD,
    RD,
    WR,
    CHK,
    NEXT,
    FIN
  } boot_state_t;

endpackage

// File: rtl/boot_image_loader.sv
// Power-on sequencer copying the BIOS and PAC flash images into SD-RAM shadow areas.
// BUSY stays high until both jobs have been copied.
module boot_image_loader
  import boot_image_loader_pkg::*;
#(
  parameter logic [23:0] BIOS_SRC = FLASH_ADDR_BIOS,
  parameter logic [23:0] BIOS_DST = RAM_ADDR_BIOS,
  parameter logic [23:0] BIOS_LEN = FLASH_SIZE_BIOS,
  parameter logic [23:0] PAC_SRC  = FLASH_ADDR_PAC,
  parameter logic [23:0] PAC_DST  = RAM_ADDR_PAC,
  parameter logic [23:0] PAC_LEN  = RAM_SIZE_PAC
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic        FLASH_REQ,
  output logic [23:0] FLASH_ADDR,
  input  logic        FLASH_ACK,
  input  logic [7:0]  FLASH_DATA,
  output logic        RAM_REQ,
  output logic [23:0] RAM_ADDR,
  output logic [7:0]  RAM_DATA,
  input  logic        RAM_ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        JOB
);

  boot_state_t state_q, state_d;
  logic [23:0] src_q, src_d;
  logic [23:0] dst_q, dst_d;
  logic [23:0] remain_q, remain_d;
  logic [7:0]  data_q, data_d;
  logic        job_q, job_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [23:0] job_src, job_dst, job_len;

  // Job table
  always_comb begin
    if (job_q) begin
      job_src = PAC_SRC;
      job_dst = PAC_DST;
      job_len = PAC_LEN;
    end else begin
      job_src = BIOS_SRC;
      job_dst = BIOS_DST;
      job_len = BIOS_LEN;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    remain_d = remain_q;
    data_d   = data_q;
    job_d    = job_q;
    busy_d   = busy_q;
    done_d   = done_q;
    unique case (state_q)
      LOAD: begin
        src_d    = job_src;
        dst_d    = job_dst;
        remain_d = job_len;
        state_d  = (job_len == 24'd0) ? NEXT : RD;
      end
      RD: begin
        // Acks are only honoured in their own state, so a stray RAM_ACK here is dropped.
        if (FLASH_ACK) begin
          data_d  = FLASH_DATA;
          state_d = WR;
        end
      end
      WR: begin
        if (RAM_ACK) begin
          src_d    = src_q + 24'd1;
          dst_d    = dst_q + 24'd1;
          remain_d = remain_q - 24'd1;
          state_d  = CHK;
        end
      end
      CHK: begin
        state_d = (remain_q == 24'd0) ? NEXT : RD;
      end
      NEXT: begin
        if (!job_q) begin
          job_d   = 1'b1;
          state_d = LOAD;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (START) begin
          job_d   = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= LOAD;
      src_q    <= 24'd0;
      dst_q    <= 24'd0;
      remain_q <= 24'd0;
      data_q   <= 8'd0;
      job_q    <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      job_q    <= job_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Requests follow the registered state, so they drop on the same edge as an ack or reset.
  assign FLASH_REQ  = (state_q == RD);
  assign FLASH_ADDR = src_q;
  assign RAM_REQ    = (state_q == WR);
  assign RAM_ADDR   = dst_q;
  assign RAM_DATA   = data_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign JOB        = job_q;

endmodule
